req_ack_sched: RTL and testbench

- Round-robin scheduler that shares a single bus resource between N_REQ requesters using a req/ack/grant handshake.
- Produces acknowledgements shaped for the team's request/acknowledge properties: an uncontended request sampled at cycle t gets ack at t+1.
- A global interrupt aborts any in-flight obligation, matching accept_on semantics in the properties.
- Sits between requester agents and the shared resource. Its ack/interrupt outputs feed the protocol checker.

---
 rtl/req_ack_pkg.sv | 49 ++++
 rtl/rr_arbiter.sv | 31 +++
 rtl/req_ack_sched.sv | 161 ++++++++++++++++
 tb/tb_req_ack_sched.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/req_ack_pkg.sv
// Shared types and helpers for the req/ack round-robin scheduler.
// Contents: FSM state enum, round-robin pick result struct,
//           rr_pick (first request at or above the pointer, wrapping) and onehot.
// Helpers are sized for the largest supported requester count (16);
// callers cast their own narrower vectors in and out.
package req_ack_pkg;

    localparam int unsigned MAX_REQ  = 16;
    localparam int unsigned MAX_ID_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        OWN   = 2'd2,
        DRAIN = 2'd3
    } sched_state_e;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] id;
    } rr_pick_t;

    // Lowest set request at index >= ptr; if none, lowest set request below ptr.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]  req,
                                         input logic [MAX_ID_W-1:0] ptr);
        rr_pick_t hi;
        rr_pick_t lo;
        hi = '0;
        lo = '0;
        // Descending scan so the last hit written is the lowest index.
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (MAX_ID_W'(i) >= ptr) begin
                    hi.found = 1'b1;
                    hi.id    = MAX_ID_W'(i);
                end else begin
                    lo.found = 1'b1;
                    lo.id    = MAX_ID_W'(i);
                end
            end
        end
        return hi.found ? hi : lo;
    endfunction

    function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_ID_W-1:0] id);
        return MAX_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick over the live request vector.
// Ports:
//   req_i     requester levels
//   ptr_i     round-robin start index (highest priority this round)
//   found_o   at least one request is set
//   win_oh_o  one-hot winner (zero when found_o=0)
//   win_id_o  winner index
// All outputs are combinational; the scheduler registers them.
module rr_arbiter
    import req_ack_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic             found_o,
    output logic [N_REQ-1:0] win_oh_o,
    output logic [ID_W-1:0]  win_id_o
);

    rr_pick_t pick;

    always_comb begin
        pick     = rr_pick(MAX_REQ'(req_i), MAX_ID_W'(ptr_i));
        found_o  = pick.found;
        win_id_o = ID_W'(pick.id);
        win_oh_o = pick.found ? N_REQ'(onehot(pick.id)) : '0;
    end

endmodule

// File: rtl/req_ack_sched.sv
// Round-robin req/ack/grant scheduler for one shared bus resource.
// Ports:
//   clk_i, rst_i      clock; synchronous active-high reset
//   req_i             level request per requester
//   done_i            release pulse, honoured only from the current owner
//   interrupt_i       level abort; cancels any ack/grant in flight
//   ack_o             one-hot single-cycle acknowledge of the winner
//   gnt_o             one-hot grant level
//   gnt_id_o          owner index, meaningful while busy_o=1
//   busy_o            high while an ack or grant is outstanding
//   abort_o           pulse when an ack/grant is cancelled by interrupt
//   timeout_o         pulse when the owner's tenure reaches HOLD_MAX
module req_ack_sched
    import req_ack_pkg::*;
#(
    parameter  int unsigned N_REQ    = 4,
    parameter  int unsigned HOLD_MAX = 8,
    localparam int unsigned CNT_W    = $clog2(HOLD_MAX + 1),
    localparam int unsigned ID_W     = $clog2(N_REQ)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] done_i,
    input  logic             interrupt_i,
    output logic [N_REQ-1:0] ack_o,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  gnt_id_o,
    output logic             busy_o,
    output logic             abort_o,
    output logic             timeout_o
);

    sched_state_e     state_q, state_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             abort_q, abort_d;
    logic             timeout_q, timeout_d;

    logic             arb_found;
    logic [N_REQ-1:0] arb_oh;
    logic [ID_W-1:0]  arb_id;
    logic             owner_rel_c;
    logic             tenure_full_c;
    logic [ID_W-1:0]  rel_ptr_c;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .found_o  (arb_found),
        .win_oh_o (arb_oh),
        .win_id_o (arb_id)
    );

    // Owner release: explicit done, or the owner dropping its request.
    assign owner_rel_c   = done_i[id_q] | ~req_i[id_q];
    assign tenure_full_c = (cnt_q == CNT_W'(HOLD_MAX));
    // Priority moves just past the departing owner.
    assign rel_ptr_c     = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);

    // Next-state and registered-output decode.
    always_comb begin
        state_d   = state_q;
        ack_d     = '0;
        gnt_d     = gnt_q;
        id_d      = id_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        abort_d   = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!interrupt_i && arb_found) begin
                    state_d = ACK;
                    ack_d   = arb_oh;
                    gnt_d   = arb_oh;
                    id_d    = arb_id;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_W'(1);
                end
            end
            ACK, OWN: begin
                if (interrupt_i) begin
                    state_d = DRAIN;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    abort_d = 1'b1;
                    ptr_d   = rel_ptr_c;
                end else if (owner_rel_c) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = rel_ptr_c;
                end else if (state_q == OWN && tenure_full_c) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                    ptr_d     = rel_ptr_c;
                end else begin
                    state_d = OWN;
                    if (!tenure_full_c) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (!interrupt_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ack_q     <= '0;
            gnt_q     <= '0;
            id_q      <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            abort_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            gnt_q     <= gnt_d;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            abort_q   <= abort_d;
            timeout_q <= timeout_d;
        end
    end

    assign ack_o     = ack_q;
    assign gnt_o     = gnt_q;
    assign gnt_id_o  = id_q;
    assign busy_o    = busy_q;
    assign abort_o   = abort_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_req_ack_sched.sv
// Self-checking bench for req_ack_sched: directed scenarios plus randomized
// requester agents, all checked every cycle against a transaction-level model
// (current owner, cycles held, draining flag, round-robin pointer).
module tb_req_ack_sched;

    localparam int unsigned N    = 4;
    localparam int unsigned HOLD = 8;
    localparam int unsigned IDW  = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   done;
    logic           intr;
    logic [N-1:0]   ack;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           abort;
    logic           timeout;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    bit m_drain = 1'b0;
    bit m_ack   = 1'b0;
    bit m_abort = 1'b0;
    bit m_to    = 1'b0;

    int rr_seq [5] = '{2, 3, 0, 1, 2};

    req_ack_sched #(.N_REQ(N), .HOLD_MAX(HOLD)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .done_i      (done),
        .interrupt_i (intr),
        .ack_o       (ack),
        .gnt_o       (gnt),
        .gnt_id_o    (gnt_id),
        .busy_o      (busy),
        .abort_o     (abort),
        .timeout_o   (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one clock edge of the rules to the model.
    task automatic model_edge(input logic r, input logic [N-1:0] rq,
                              input logic [N-1:0] dn, input logic it);
        m_ack   = 1'b0;
        m_abort = 1'b0;
        m_to    = 1'b0;
        if (r) begin
            m_owner = -1;
            m_held  = 0;
            m_ptr   = 0;
            m_drain = 1'b0;
        end else if (m_drain) begin
            if (!it) m_drain = 1'b0;
        end else if (m_owner >= 0) begin
            if (it) begin
                m_abort = 1'b1;
                m_drain = 1'b1;
                m_ptr   = (m_owner + 1) % int'(N);
                m_owner = -1;
            end else if (dn[m_owner] || !rq[m_owner]) begin
                m_ptr   = (m_owner + 1) % int'(N);
                m_owner = -1;
            end else if (m_held >= int'(HOLD) && m_held >= 2) begin
                m_to    = 1'b1;
                m_ptr   = (m_owner + 1) % int'(N);
                m_owner = -1;
            end else begin
                m_held++;
            end
        end else if (!it) begin
            for (int k = 0; k < int'(N); k++) begin
                int i;
                i = (m_ptr + k) % int'(N);
                if (rq[i]) begin
                    m_owner = i;
                    m_held  = 1;
                    m_ack   = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] e_gnt;
        e_gnt = (m_owner >= 0) ? oh(m_owner) : '0;
        chk("ack",     32'(ack),     32'(m_ack ? e_gnt : '0));
        chk("gnt",     32'(gnt),     32'(e_gnt));
        chk("busy",    32'(busy),    32'(m_owner >= 0));
        chk("abort",   32'(abort),   32'(m_abort));
        chk("timeout", 32'(timeout), 32'(m_to));
        if (m_owner >= 0) chk("gnt_id", 32'(gnt_id), 32'(m_owner));
    endtask

    // One cycle: drive inputs, clock, advance the model, compare.
    task automatic cyc(input logic r, input logic [N-1:0] rq,
                       input logic [N-1:0] dn, input logic it);
        rst  = r;
        req  = rq;
        done = dn;
        intr = it;
        @(posedge clk);
        model_edge(r, rq, dn, it);
        #1;
        check_outputs();
    endtask

    initial begin
        logic [N-1:0] rq;
        logic [N-1:0] dn;
        logic         it;
        int           burst;

        // Reset state.
        cyc(1'b1, '0, '0, 1'b0);
        cyc(1'b1, '0, '0, 1'b0);
        chk("rst_ack",    32'(ack),     32'(0));
        chk("rst_gnt",    32'(gnt),     32'(0));
        chk("rst_gnt_id", 32'(gnt_id),  32'(0));
        chk("rst_busy",   32'(busy),    32'(0));
        chk("rst_abort",  32'(abort),   32'(0));
        chk("rst_to",     32'(timeout), 32'(0));

        // Single request: ack one cycle after sampling, done three cycles later.
        cyc(1'b0, 4'b0010, '0, 1'b0);
        chk("single_ack", 32'(ack),    32'(4'b0010));
        chk("single_id",  32'(gnt_id), 32'(1));
        cyc(1'b0, 4'b0010, '0, 1'b0);
        chk("single_ack_off", 32'(ack), 32'(0));
        cyc(1'b0, 4'b0010, '0, 1'b0);
        cyc(1'b0, 4'b0010, 4'b0010, 1'b0);
        chk("single_rel", 32'(gnt), 32'(0));
        cyc(1'b0, '0, '0, 1'b0);

        // Full contention: round-robin order from pointer 2, one idle cycle between owners.
        for (int g = 0; g < 5; g++) begin
            cyc(1'b0, 4'b1111, '0, 1'b0);
            chk("rr_order", 32'(ack), 32'(oh(rr_seq[g])));
            cyc(1'b0, 4'b1111, '0, 1'b0);
            cyc(1'b0, 4'b1111, oh(rr_seq[g]), 1'b0);
            chk("rr_gap", 32'(busy), 32'(0));
        end

        // Tenure expiry of requester 2, then requester 3 goes first.
        for (int c = 0; c < 9; c++) cyc(1'b0, 4'b0100, '0, 1'b0);
        chk("to_pulse", 32'(timeout), 32'(1));
        chk("to_gnt",   32'(gnt),     32'(0));
        cyc(1'b0, 4'b1100, '0, 1'b0);
        chk("to_next", 32'(ack), 32'(4'b1000));
        cyc(1'b0, 4'b1100, 4'b1000, 1'b0);
        cyc(1'b0, '0, '0, 1'b0);

        // Interrupt while owner 1 holds the grant.
        cyc(1'b0, 4'b0010, '0, 1'b0);
        cyc(1'b0, 4'b0010, '0, 1'b0);
        cyc(1'b0, 4'b0110, '0, 1'b1);
        chk("irq_abort", 32'(abort), 32'(1));
        chk("irq_gnt",   32'(gnt),   32'(0));
        cyc(1'b0, 4'b0110, '0, 1'b1);
        cyc(1'b0, 4'b0110, '0, 1'b1);
        chk("irq_noack", 32'(ack), 32'(0));
        cyc(1'b0, 4'b0110, '0, 1'b0);
        chk("irq_idle", 32'(ack), 32'(0));
        cyc(1'b0, 4'b0110, '0, 1'b0);
        chk("irq_next", 32'(ack), 32'(4'b0100));
        cyc(1'b0, 4'b0100, 4'b0100, 1'b0);

        // Interrupt held while a request waits.
        cyc(1'b0, 4'b0001, '0, 1'b1);
        cyc(1'b0, 4'b0001, '0, 1'b1);
        chk("irq_req_noack", 32'(ack), 32'(0));
        cyc(1'b0, 4'b0001, '0, 1'b0);
        chk("irq_req_ack", 32'(ack), 32'(4'b0001));
        cyc(1'b0, '0, '0, 1'b0);

        // Randomized requester agents with done/drop/interrupt mixing.
        rq    = '0;
        burst = 0;
        for (int c = 0; c < 1600; c++) begin
            for (int i = 0; i < int'(N); i++) begin
                if (!rq[i]) rq[i] = ($urandom % 4 == 0);
                else if ($urandom % 40 == 0) rq[i] = 1'b0;
            end
            dn = '0;
            if (m_owner >= 0 && ($urandom % ((c < 800) ? 5 : 15) == 0)) dn[m_owner] = 1'b1;
            if ($urandom % 12 == 0) dn[$urandom % N] = 1'b1;
            if (burst > 0) begin
                it = 1'b1;
                burst--;
            end else if ($urandom % 25 == 0) begin
                it    = 1'b1;
                burst = int'($urandom_range(0, 3));
            end else begin
                it = 1'b0;
            end
            cyc(1'b0, rq, dn, it);
            rq = rq & ~dn;
        end

        // Reset in the middle of owner 3's tenure.
        cyc(1'b0, '0, '0, 1'b0);
        cyc(1'b0, '0, '0, 1'b0);
        cyc(1'b0, 4'b1000, '0, 1'b0);
        chk("rst_mid_ack", 32'(ack), 32'(4'b1000));
        cyc(1'b0, 4'b1000, '0, 1'b0);
        cyc(1'b1, 4'b1111, '0, 1'b0);
        chk("rst_mid_gnt",   32'(gnt),   32'(0));
        chk("rst_mid_abort", 32'(abort), 32'(0));
        chk("rst_mid_busy",  32'(busy),  32'(0));
        cyc(1'b0, 4'b1111, '0, 1'b0);
        chk("rst_mid_first", 32'(ack), 32'(4'b0001));
        cyc(1'b0, '0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
